// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: funct3 load encodings, FSM state encodings
// and the misalignment rule.
package load_align_unit_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq0  = 3'd1;
  localparam logic [2:0] StWait0 = 3'd2;
  localparam logic [2:0] StReq1  = 3'd3;
  localparam logic [2:0] StWait1 = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  function automatic logic is_legal_load(input logic [2:0] funct3);
    case (funct3)
      F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // True when the access crosses a word boundary and needs a second word read.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3Lh, F3Lhu: return off == 2'd3;
      F3Lw:        return off != 2'd0;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/half/word extraction from a two-word window, with sign or zero extension.
module load_extract
  import load_align_unit_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [63:0] dword;
  logic [31:0] x;

  always_comb begin
    dword = {w1_i, w0_i} >> {off_i, 3'b000};
    x     = dword[31:0];
    case (funct3_i)
      F3Lb:    data_o = {{24{x[7]}}, x[7:0]};
      F3Lbu:   data_o = {24'b0, x[7:0]};
      F3Lh:    data_o = {{16{x[15]}}, x[15:0]};
      F3Lhu:   data_o = {16'b0, x[15:0]};
      default: data_o = x;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// RV32 load alignment unit: fetches one or two words from dmem, extracts and extends the
// addressed byte/half/word, and presents it to writeback with a valid/ready handshake.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        split;
  logic [31:0] base_addr;
  logic [31:0] ext_w0, ext_w1, ext_data;

  assign split     = is_misaligned(funct3_q, addr_q[1:0]);
  assign base_addr = {addr_q[31:2], 2'b00};

  // Feed the arriving word straight into the extractor so the result registers on RESP entry.
  assign ext_w0 = (state_q == StWait0) ? mem_rdata_i : w0_q;
  assign ext_w1 = (state_q == StWait1) ? mem_rdata_i : 32'h0;

  load_extract u_extract (
    .w0_i    (ext_w0),
    .w1_i    (ext_w1),
    .off_i   (addr_q[1:0]),
    .funct3_i(funct3_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    w0_d     = w0_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          funct3_d = req_funct3_i;
          if (!is_legal_load(req_funct3_i) ||
              (!SPLIT_MISALIGNED && is_misaligned(req_funct3_i, req_addr_i[1:0]))) begin
            state_d = StResp;
            data_d  = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = StReq0;
          end
        end
      end
      StReq0: begin
        if (mem_req_ready_i) state_d = StWait0;
      end
      StWait0: begin
        if (mem_rvalid_i) begin
          w0_d = mem_rdata_i;
          if (split) begin
            state_d = StReq1;
          end else begin
            state_d = StResp;
            data_d  = ext_data;
            err_d   = 1'b0;
          end
        end
      end
      StReq1: begin
        if (mem_req_ready_i) state_d = StWait1;
      end
      StWait1: begin
        if (mem_rvalid_i) begin
          state_d = StResp;
          data_d  = ext_data;
          err_d   = 1'b0;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      w0_q     <= 32'h0;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      w0_q     <= w0_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o     = (state_q == StIdle);
  assign mem_req_valid_o = (state_q == StReq0) || (state_q == StReq1);
  assign mem_addr_o      = ((state_q == StReq1) || (state_q == StWait1)) ? base_addr + 32'd4
                                                                         : base_addr;
  assign resp_valid_o    = (state_q == StResp);
  assign resp_data_o     = data_q;
  assign resp_err_o      = err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: a byte-addressed memory responder plus a reference
// model that assembles loads byte by byte.
module tb_load_align_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = 32'h0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic        resp_err_o;

  load_align_unit dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_funct3_i   (req_funct3_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_data_o    (resp_data_o),
    .resp_err_o     (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_log[$];
  int rdelay = 1;
  int ready_pct = 100;
  int ready_hold = 0;
  int mreq_cnt = 0;
  int stall_cnt = 0;
  int addr_unstable = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Reference: gather n bytes little-endian from byte addresses a..a+n-1, then extend.
  function automatic void ref_load(input logic [31:0] a, input logic [2:0] f3,
                                   output logic [31:0] d, output bit err, output int naddr,
                                   output logic [31:0] a0, output logic [31:0] a1);
    int n;
    bit sgn;
    logic [63:0] v;
    logic [31:0] ba, w;
    n = 0; sgn = 0; err = 0;
    case (f3)
      3'b000: begin n = 1; sgn = 1; end
      3'b001: begin n = 2; sgn = 1; end
      3'b010: begin n = 4; sgn = 0; end
      3'b100: begin n = 1; sgn = 0; end
      3'b101: begin n = 2; sgn = 0; end
      default: err = 1;
    endcase
    d = 0; naddr = 0; a0 = 0; a1 = 0;
    if (err) return;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      w  = mem_rd(ba & 32'hFFFF_FFFC);
      v  = v + (64'((w >> (8 * ba[1:0])) & 32'hFF) << (8 * i));
    end
    if (sgn && v[8*n-1]) v = v - (64'd1 << (8 * n));
    d = v[31:0];
    a0 = a & 32'hFFFF_FFFC;
    a1 = (a + n - 1) & 32'hFFFF_FFFC;
    naddr = (a1 != a0) ? 2 : 1;
  endfunction

  // Memory responder: one outstanding read, rvalid rdelay cycles after acceptance.
  initial begin
    bit hs, pend, prev_wait;
    int cnt;
    logic [31:0] paddr, prev_addr;
    hs = 0; pend = 0; prev_wait = 0; cnt = 0; paddr = 0; prev_addr = 0;
    forever begin
      @(negedge clk_i);
      hs = mem_req_valid_o && mem_req_ready_i;
      if (mem_req_valid_o) mreq_cnt++;
      if (mem_req_valid_o && !mem_req_ready_i) stall_cnt++;
      if (prev_wait && mem_req_valid_o && mem_addr_o !== prev_addr) addr_unstable++;
      prev_wait = mem_req_valid_o && !mem_req_ready_i;
      prev_addr = mem_addr_o;
      if (hs) begin
        paddr = mem_addr_o;
        addr_log.push_back(mem_addr_o);
      end
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (!rst_ni) begin
        pend = 0; hs = 0; prev_wait = 0;
      end
      if (hs) begin
        pend = 1; cnt = rdelay;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 0;
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_rd(paddr);
        end
      end
      if (ready_hold > 0) begin
        mem_req_ready_i = 1'b0;
        ready_hold--;
      end else begin
        mem_req_ready_i = ($urandom_range(1, 100) <= ready_pct);
      end
    end
  end

  // Issues one load, holds resp_ready low for rhold cycles, returns what the DUT produced.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int rhold,
                         output logic [31:0] data, output bit err, output int lat,
                         output bit timeout, output int unstable);
    int cyc;
    timeout = 0; unstable = 0; lat = 0; data = 0; err = 0;
    addr_log.delete();
    mreq_cnt = 0;
    stall_cnt = 0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1; req_addr_i = a; req_funct3_i = f3;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!req_ready_o && cyc < 50);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; req_addr_i = $urandom; req_funct3_i = 3'($urandom);
    do begin
      @(negedge clk_i);
      lat++;
    end while (!resp_valid_o && lat < 200);
    if (!resp_valid_o) begin
      timeout = 1;
      return;
    end
    data = resp_data_o;
    err  = resp_err_o;
    for (int k = 0; k < rhold; k++) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b1 || resp_data_o !== data || resp_err_o !== err) unstable++;
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    checks += 6;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b want 1", req_ready_o);
    end
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid_o);
    end
    if (mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_o);
    end
    if (resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid_o);
    end
    if (resp_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_resp_data got %h want 0", resp_data_o);
    end
    if (resp_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_resp_err got %b want 0", resp_err_o);
    end
  endtask

  task automatic test_directed;
    logic [31:0] d;
    bit e, to;
    int lat, un;
    ready_pct = 100; rdelay = 1; ready_hold = 0;
    mem[32'h0000_2000] = 32'h80FF_1234;
    mem[32'h0000_3000] = 32'h8001_0000;
    mem[32'h0000_1000] = 32'hDDCC_BBAA;
    mem[32'h0000_1004] = 32'h4433_2211;

    do_load(32'h0000_2003, 3'b000, 0, d, e, lat, to, un);
    checks++;
    if (to || d !== 32'hFFFF_FF80 || e !== 1'b0) begin
      errors++; $display("FAIL lb_sign got %h err %b want ffffff80 err 0", d, e);
    end
    do_load(32'h0000_2003, 3'b100, 0, d, e, lat, to, un);
    checks++;
    if (to || d !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_zero got %h want 00000080", d);
    end

    do_load(32'h0000_3002, 3'b001, 0, d, e, lat, to, un);
    checks += 3;
    if (to || d !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh_sign got %h want ffff8001", d);
    end
    if (addr_log.size() != 1) begin
      errors++; $display("FAIL lh_one_req got %0d reqs want 1", addr_log.size());
    end
    if (lat != 3) begin
      errors++; $display("FAIL lh_latency got %0d want 3", lat);
    end

    do_load(32'h0000_1001, 3'b010, 0, d, e, lat, to, un);
    checks += 2;
    if (to || d !== 32'h11DD_CCBB) begin
      errors++; $display("FAIL lw_split_data got %h want 11ddccbb", d);
    end
    if (addr_log.size() != 2 || addr_log[0] !== 32'h1000 || addr_log[1] !== 32'h1004) begin
      errors++; $display("FAIL lw_split_addrs got %0d reqs want 0x1000,0x1004", addr_log.size());
    end

    do_load(32'hFFFF_FFFE, 3'b010, 0, d, e, lat, to, un);
    checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0) begin
      errors++; $display("FAIL lw_wrap_addr got %0d reqs want fffffffc,00000000",
                         addr_log.size());
    end
  endtask

  task automatic test_illegal;
    logic [31:0] d;
    bit e, to;
    int lat, un;
    logic [2:0] bad [3];
    bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      do_load($urandom, bad[i], 1, d, e, lat, to, un);
      checks++;
      if (to || e !== 1'b1 || d !== 32'h0 || mreq_cnt != 0) begin
        errors++;
        $display("FAIL illegal_f3 f3 %b got err %b data %h memreqs %0d want err 1 data 0 reqs 0",
                 bad[i], e, d, mreq_cnt);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] d, ed, a, a0, a1;
    logic [2:0] f3;
    bit e, ee, to;
    int lat, un, na;
    for (int i = 0; i < 40; i++) begin
      ready_pct = $urandom_range(40, 100);
      rdelay    = $urandom_range(1, 3);
      a  = $urandom;
      f3 = 3'($urandom);
      ref_load(a, f3, ed, ee, na, a0, a1);
      do_load(a, f3, $urandom_range(0, 2), d, e, lat, to, un);
      checks++;
      if (to || d !== ed || e !== ee || un != 0 || addr_log.size() != na ||
          (na > 0 && addr_log[0] !== a0) || (na > 1 && addr_log[1] !== a1)) begin
        errors++;
        $display("FAIL random addr %h f3 %b got %h err %b reqs %0d want %h err %b reqs %0d",
                 a, f3, d, e, addr_log.size(), ed, ee, na);
      end
    end
    ready_pct = 100; rdelay = 1;
  endtask

  task automatic test_stall;
    logic [31:0] d, ed, a0, a1;
    bit e, ee, to;
    int lat, un, na;
    ref_load(32'h0000_1002, 3'b010, ed, ee, na, a0, a1);
    ready_pct = 100; rdelay = 2; ready_hold = 8;
    do_load(32'h0000_1002, 3'b010, 3, d, e, lat, to, un);
    checks += 3;
    if (stall_cnt < 5 || addr_unstable != 0) begin
      errors++; $display("FAIL stall_mem_addr stalls %0d changes %0d want >=5 and 0",
                         stall_cnt, addr_unstable);
    end
    if (un != 0) begin
      errors++; $display("FAIL stall_resp_hold changes %0d want 0", un);
    end
    if (to || d !== ed) begin
      errors++; $display("FAIL stall_data got %h want %h", d, ed);
    end
    rdelay = 1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, ed, a0, a1;
    bit e, ee, to;
    int lat, un, na, cyc;
    ready_pct = 100; rdelay = 8; ready_hold = 0;
    addr_log.delete();
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1; req_addr_i = 32'h0000_4001; req_funct3_i = 3'b010;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (addr_log.size() == 0 && cyc < 20);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || mem_addr_o !== 32'h0 ||
        resp_valid_o !== 1'b0 || resp_data_o !== 32'h0 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset rdy %b mreq %b maddr %h rv %b rd %h re %b want 1 0 0 0 0 0",
               req_ready_o, mem_req_valid_o, mem_addr_o, resp_valid_o, resp_data_o, resp_err_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    rdelay = 1;
    ref_load(32'h0000_4006, 3'b101, ed, ee, na, a0, a1);
    do_load(32'h0000_4006, 3'b101, 0, d, e, lat, to, un);
    checks++;
    if (to || d !== ed || e !== ee || lat != 3) begin
      errors++; $display("FAIL after_reset got %h lat %0d want %h lat 3", d, lat, ed);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
